// File: rtl/display_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller: blank/on slot timing,
// frame-synchronous shadow update and optional leading-zero suppression.
module display_scan_ctrl #(
    parameter int N_DIGITS     = 8,
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 16,
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1,
    localparam int CW = $clog2(DIGIT_CYCLES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_mask,
    input  logic                  lz_en,
    output logic [3:0]            nibble,
    output logic [N_DIGITS-1:0]   anode_n,
    output logic                  dp_n,
    output logic [IW-1:0]         digit_idx,
    output logic                  frame_done
);

    typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*N_DIGITS-1:0] pend_val_q, pend_val_d, shd_val_q, shd_val_d;
    logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d, shd_dp_q, shd_dp_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [3:0]            nibble_q, nibble_d;
    logic [N_DIGITS-1:0]   anode_q, anode_d;
    logic                  dp_q, dp_d;
    logic                  fdone_q, fdone_d;
    logic                  boundary;
    logic [N_DIGITS-1:0]   lead_zero;
    logic                  supp;
    int                    sel;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        fdone_d    = 1'b0;
        boundary   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (enable) begin
                    state_d  = BLANK;
                    boundary = 1'b1;
                end
            end
            BLANK: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(BLANK_CYCLES - 1)) state_d = ON;
            end
            ON: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DIGIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = BLANK;
                    if (idx_q == IW'(N_DIGITS - 1)) begin
                        idx_d    = '0;
                        boundary = 1'b1;
                        fdone_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Disable overrides everything: the slot is abandoned, no boundary.
        if (!enable) begin
            state_d  = IDLE;
            cnt_d    = '0;
            idx_d    = '0;
            fdone_d  = 1'b0;
            boundary = 1'b0;
        end
    end

    always_comb begin
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pend_vld_d = pend_vld_q;
        shd_val_d  = shd_val_q;
        shd_dp_d   = shd_dp_q;
        if (boundary) begin
            pend_vld_d = 1'b0;
            if (load) begin
                shd_val_d = value;
                shd_dp_d  = dp_mask;
            end else if (pend_vld_q) begin
                shd_val_d = pend_val_q;
                shd_dp_d  = pend_dp_q;
            end
        end else if (load) begin
            pend_val_d = value;
            pend_dp_d  = dp_mask;
            pend_vld_d = 1'b1;
        end
    end

    // lead_zero[i]: shadow nibbles i..N_DIGITS-1 are all zero.
    always_comb begin
        lead_zero = '0;
        lead_zero[N_DIGITS-1] = (shd_val_d[4*N_DIGITS-4 +: 4] == 4'd0);
        for (int i = N_DIGITS - 2; i >= 0; i--)
            lead_zero[i] = lead_zero[i+1] && (shd_val_d[4*i +: 4] == 4'd0);
    end

    // Outputs are computed from next-state values so the registered outputs
    // line up with the state they describe.
    always_comb begin
        sel      = int'(idx_d);
        supp     = lz_en && (idx_d != '0) && lead_zero[sel] && !shd_dp_d[sel];
        anode_d  = '1;
        nibble_d = 4'd0;
        dp_d     = 1'b1;
        if (state_d != IDLE && !supp) begin
            nibble_d = shd_val_d[4*sel +: 4];
            dp_d     = ~shd_dp_d[sel];
            if (state_d == ON) anode_d[sel] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            pend_vld_q <= 1'b0;
            shd_val_q  <= '0;
            shd_dp_q   <= '0;
            nibble_q   <= 4'd0;
            anode_q    <= '1;
            dp_q       <= 1'b1;
            fdone_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            pend_vld_q <= pend_vld_d;
            shd_val_q  <= shd_val_d;
            shd_dp_q   <= shd_dp_d;
            nibble_q   <= nibble_d;
            anode_q    <= anode_d;
            dp_q       <= dp_d;
            fdone_q    <= fdone_d;
        end
    end

    assign nibble     = nibble_q;
    assign anode_n    = anode_q;
    assign dp_n       = dp_q;
    assign digit_idx  = idx_q;
    assign frame_done = fdone_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: a cycle-time reference model pushes
// expected outputs each edge; a negedge monitor pops and compares.
module tb_display_scan_ctrl;

    localparam int N     = 4;
    localparam int DC    = 8;
    localparam int BC    = 2;
    localparam int FRAME = N * DC;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] nib;
        logic       dp;
        logic [1:0] idx;
        logic       fd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_mask = '0;
    logic        lz_en = 1'b0;
    logic [3:0]  nibble;
    logic [3:0]  anode_n;
    logic        dp_n;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    display_scan_ctrl #(.N_DIGITS(N), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
        .dp_mask(dp_mask), .lz_en(lz_en), .nibble(nibble), .anode_n(anode_n),
        .dp_n(dp_n), .digit_idx(digit_idx), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: time since scanning started, frame-boundary data swap.
    exp_t        sb[$];
    exp_t        idle_e = '{an: 4'hF, nib: 4'h0, dp: 1'b1, idx: 2'd0, fd: 1'b0};
    bit          m_run = 0;
    int          m_t = 0;
    logic [15:0] m_pend = '0, m_shd = '0;
    logic [3:0]  m_pdp = '0, m_sdp = '0;
    bit          m_pv = 0;
    bit          m_bnd, m_fd, m_sup, m_on;
    int          m_dig;
    logic [15:0] m_hi;
    exp_t        m_e;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_run = 0; m_t = 0; m_pend = '0; m_pdp = '0; m_pv = 0;
            m_shd = '0; m_sdp = '0;
            m_e = idle_e;
        end else begin
            m_bnd = 0; m_fd = 0;
            if (!enable) m_run = 0;
            else if (!m_run) begin m_run = 1; m_t = 0; m_bnd = 1; end
            else begin
                m_t++;
                if (m_t % FRAME == 0) begin m_bnd = 1; m_fd = 1; end
            end
            if (m_bnd) begin
                if (load) begin m_shd = value; m_sdp = dp_mask; end
                else if (m_pv) begin m_shd = m_pend; m_sdp = m_pdp; end
                m_pv = 0;
            end else if (load) begin
                m_pend = value; m_pdp = dp_mask; m_pv = 1;
            end
            if (!m_run) m_e = idle_e;
            else begin
                m_dig = (m_t / DC) % N;
                m_on  = (m_t % DC) >= BC;
                m_hi  = m_shd >> (4 * m_dig);
                m_sup = lz_en && m_dig > 0 && m_hi == 0 && !m_sdp[m_dig];
                m_e.nib = m_sup ? 4'h0 : m_hi[3:0];
                m_e.dp  = m_sup ? 1'b1 : !m_sdp[m_dig];
                m_e.an  = (m_on && !m_sup) ? ~(4'b0001 << m_dig) : 4'hF;
                m_e.idx = 2'(m_dig);
                m_e.fd  = m_fd;
            end
        end
        sb.push_back(m_e);
    end

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (!rst_n) e = idle_e;
            chk("anode_n", int'(anode_n), int'(e.an));
            chk("nibble", int'(nibble), int'(e.nib));
            chk("dp_n", int'(dp_n), int'(e.dp));
            chk("digit_idx", int'(digit_idx), int'(e.idx));
            chk("frame_done", int'(frame_done), int'(e.fd));
            chk("anode_onehot", int'($countones(~anode_n) <= 1), 1);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        load = 1'b1; value = v; dp_mask = d;
        tick(1);
        load = 1'b0; value = $urandom; dp_mask = 4'($urandom);
    endtask

    // Advance until the model's run time satisfies t % FRAME == ph.
    task automatic wait_phase(input int ph);
        int guard = 0;
        while (!(m_run && (m_t % FRAME) == ph) && guard < 200) begin
            tick(1); guard++;
        end
        chk("wait_phase_timeout", int'(guard < 200), 1);
    endtask

    initial begin
        tick(3);
        rst_n = 1'b1;
        tick(2);
        do_load(16'h1234, 4'b0000);
        enable = 1'b1;
        tick(2 * FRAME);

        wait_phase(DC + 3);
        do_load(16'hABCD, 4'b0010);
        tick(FRAME + 5);

        wait_phase(FRAME - 1);
        do_load(16'h5E6F, 4'b0100);
        tick(FRAME);

        lz_en = 1'b1;
        do_load(16'h0070, 4'b0000);
        tick(2 * FRAME);
        do_load(16'h0070, 4'b1000);
        tick(2 * FRAME);
        do_load(16'h0000, 4'b0000);
        tick(FRAME + 4);

        wait_phase(2 * DC + 4);
        enable = 1'b0;
        tick(3);
        enable = 1'b1;
        tick(FRAME + 6);

        wait_phase(DC + 5);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_anode", int'(anode_n), 4'hF);
        chk("async_rst_dp", int'(dp_n), 1);
        chk("async_rst_fd", int'(frame_done), 0);
        @(posedge clk); #2;
        tick(2);
        rst_n = 1'b1;
        tick(FRAME + 3);

        for (int i = 0; i < 600; i++) begin
            lz_en  = 1'($urandom_range(0, 3) == 0);
            enable = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 9) == 0) begin
                load = 1'b1; value = $urandom; dp_mask = 4'($urandom);
                if ($urandom_range(0, 1) == 0) value[15:8] = 8'h00;
            end else load = 1'b0;
            tick(1);
        end
        load = 1'b0;
        tick(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
